// File: rtl/ram_access_arbiter_if.sv
// Requester and RAM-port bundle for ram_access_arbiter.
// slave = arbiter side, master = client/RAM side.
interface ram_access_arbiter_if #(
  parameter int AW = 3,
  parameter int DW = 8
);
  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_gnt;
  logic          a_rvalid;
  logic [DW-1:0] a_rdata;

  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_gnt;
  logic          b_rvalid;
  logic [DW-1:0] b_rdata;

  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data_in;
  logic          ram_we;
  logic [DW-1:0] ram_data_out;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    output ram_address, ram_data_in, ram_we,
    input  ram_data_out
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  ram_address, ram_data_in, ram_we,
    output ram_data_out
  );
endinterface

// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter for a shared single-port RAM,
// with tagged read return and a bulk-clear sequencer.
module ram_access_arbiter #(
  parameter int            AW   = 3,
  parameter int            DW   = 8,
  parameter logic [DW-1:0] FILL = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_req,
  output logic clr_busy,
  output logic clr_done,
  ram_access_arbiter_if.slave bus
);

  typedef enum logic {SERVE, CLEAR} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          last_b_q, last_b_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic          done_q, done_d;
  logic          t1_v_q, t1_v_d;
  logic          t1_b_q, t1_b_d;
  logic          a_rv_q, b_rv_q;
  logic          pick_a, pick_b;

  // Contention goes to whoever was not granted last.
  assign pick_a = bus.a_req &&
                  (!bus.b_req || last_b_q);
  assign pick_b = bus.b_req && !pick_a;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_b_d  = last_b_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    din_d     = din_q;
    done_d    = 1'b0;
    t1_v_d    = 1'b0;
    t1_b_d    = t1_b_q;
    bus.a_gnt = 1'b0;
    bus.b_gnt = 1'b0;
    unique case (state_q)
      SERVE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else begin
          unique case (1'b1)
            pick_a: begin
              bus.a_gnt = 1'b1;
              last_b_d  = 1'b0;
              we_d      = bus.a_we;
              addr_d    = bus.a_addr;
              din_d     = bus.a_wdata;
              t1_v_d    = !bus.a_we;
              t1_b_d    = 1'b0;
            end
            pick_b: begin
              bus.b_gnt = 1'b1;
              last_b_d  = 1'b1;
              we_d      = bus.b_we;
              addr_d    = bus.b_addr;
              din_d     = bus.b_wdata;
              t1_v_d    = !bus.b_we;
              t1_b_d    = 1'b1;
            end
            default: ;
          endcase
        end
      end
      CLEAR: begin
        we_d   = 1'b1;
        addr_d = cnt_q;
        din_d  = FILL;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = SERVE;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SERVE;
      cnt_q    <= '0;
      last_b_q <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      done_q   <= 1'b0;
      t1_v_q   <= 1'b0;
      t1_b_q   <= 1'b0;
      a_rv_q   <= 1'b0;
      b_rv_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_b_q <= last_b_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      done_q   <= done_d;
      t1_v_q   <= t1_v_d;
      t1_b_q   <= t1_b_d;
      // Second tag stage lines up with RAM read data.
      a_rv_q   <= t1_v_q && !t1_b_q;
      b_rv_q   <= t1_v_q && t1_b_q;
    end
  end

  assign bus.ram_we      = we_q;
  assign bus.ram_address = addr_q;
  assign bus.ram_data_in = din_q;
  assign bus.a_rvalid    = a_rv_q;
  assign bus.b_rvalid    = b_rv_q;
  assign bus.a_rdata     = bus.ram_data_out;
  assign bus.b_rdata     = bus.ram_data_out;
  assign clr_busy        = (state_q == CLEAR);
  assign clr_done        = done_q;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Randomised bench for ram_access_arbiter against
// a transaction-level model of grants, memory and reads.
module tb_ram_access_arbiter;
  localparam int AW = 3;
  localparam int DW = 8;
  localparam logic [7:0] FILL = 8'hFF;

  logic clk = 1'b0;
  logic rst;
  logic clr_req;
  logic clr_busy;
  logic clr_done;

  ram_access_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  ram_access_arbiter #(
    .AW(AW), .DW(DW), .FILL(FILL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clr_req(clr_req),
    .clr_busy(clr_busy),
    .clr_done(clr_done),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [8];
  always @(posedge clk) begin
    bus.ram_data_out <= ram[bus.ram_address];
    if (bus.ram_we)
      ram[bus.ram_address] <= bus.ram_data_in;
  end

  typedef struct {
    int         due;
    bit         b;
    logic [7:0] d;
  } rd_t;

  rd_t        rq[$];
  logic [7:0] mem [8];
  int         cyc;
  bit         last_b;
  int         clear_left;
  bit         done_pend;
  bit         xw;
  logic [2:0] xaddr;
  logic [7:0] xdin;
  bit         g_a, g_b;
  int         n_vec, n_bad;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    rq.delete();
    last_b     = 1'b1;
    clear_left = 0;
    done_pend  = 1'b0;
    xw         = 1'b0;
  endtask

  task automatic drive_a(bit r, bit w, int ad, int wd);
    bus.a_req   = r;
    bus.a_we    = w;
    bus.a_addr  = 3'(ad);
    bus.a_wdata = 8'(wd);
  endtask

  task automatic drive_b(bit r, bit w, int ad, int wd);
    bus.b_req   = r;
    bus.b_we    = w;
    bus.b_addr  = 3'(ad);
    bus.b_wdata = 8'(wd);
  endtask

  // One clock: check at negedge, advance model, return after posedge.
  task automatic step();
    bit         ea, eb, busy_e, done_e, nw;
    logic [7:0] ed;
    logic [2:0] na;
    logic [7:0] nd;
    rd_t        r;
    @(negedge clk);
    ea = 0; eb = 0; ed = '0;
    g_a = 0; g_b = 0;
    nw = 0; na = '0; nd = '0;
    busy_e = (clear_left > 0);
    done_e = done_pend;
    done_pend = 0;
    if (clear_left > 0) begin
      nw = 1;
      na = 3'(8 - clear_left);
      nd = FILL;
      clear_left--;
      if (clear_left == 0) done_pend = 1;
    end else if (clr_req) begin
      clear_left = 8;
      for (int i = 0; i < 8; i++) mem[i] = FILL;
    end else if (bus.a_req && (!bus.b_req || last_b)) begin
      g_a = 1;
    end else if (bus.b_req) begin
      g_b = 1;
    end
    chk("a_gnt", bus.a_gnt, g_a);
    chk("b_gnt", bus.b_gnt, g_b);
    chk("clr_busy", clr_busy, busy_e);
    chk("clr_done", clr_done, done_e);
    chk("ram_we", bus.ram_we, xw);
    if (xw) begin
      chk("ram_address", bus.ram_address, xaddr);
      chk("ram_data_in", bus.ram_data_in, xdin);
    end
    if (rq.size() > 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      ea = !r.b;
      eb = r.b;
      ed = r.d;
    end
    chk("a_rvalid", bus.a_rvalid, ea);
    chk("b_rvalid", bus.b_rvalid, eb);
    if (ea) chk("a_rdata", bus.a_rdata, ed);
    if (eb) chk("b_rdata", bus.b_rdata, ed);
    if (g_a || g_b) begin
      bit         w;
      logic [2:0] ad;
      logic [7:0] wd;
      w  = g_a ? bus.a_we : bus.b_we;
      ad = g_a ? bus.a_addr : bus.b_addr;
      wd = g_a ? bus.a_wdata : bus.b_wdata;
      last_b = g_b;
      if (w) begin
        mem[ad] = wd;
        nw = 1; na = ad; nd = wd;
      end else begin
        rq.push_back('{cyc + 2, g_b, mem[ad]});
      end
    end
    xw = nw; xaddr = na; xdin = nd;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(int budget);
    int n = 0;
    while ((bus.a_req || bus.b_req) && n < budget) begin
      step();
      if (g_a) bus.a_req = 0;
      if (g_b) bus.b_req = 0;
      n++;
    end
    chk("drain", {31'b0, bus.a_req || bus.b_req}, 0);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_reset_vals();
    chk("rst_we", bus.ram_we, 0);
    chk("rst_addr", bus.ram_address, 0);
    chk("rst_din", bus.ram_data_in, 0);
    chk("rst_busy", clr_busy, 0);
    chk("rst_done", clr_done, 0);
    chk("rst_a_rv", bus.a_rvalid, 0);
    chk("rst_b_rv", bus.b_rvalid, 0);
  endtask

  initial begin
    int n;
    bit pa, pb;
    n_vec = 0; n_bad = 0; cyc = 0;
    rst = 1; clr_req = 0;
    drive_a(0, 0, 0, 0);
    drive_b(0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals();
    rst = 0;

    // Known memory contents to start from.
    clr_req = 1; step(); clr_req = 0;
    idle(10);

    // A write then read of addr 3.
    drive_a(1, 1, 3, 8'h5A); drain(4);
    drive_a(1, 0, 3, 0); drain(4);
    idle(3);

    // Preload 1/2, then continuous contention reads.
    drive_a(1, 1, 1, 8'h11);
    drive_b(1, 1, 2, 8'h22);
    drain(6);
    drive_a(1, 0, 1, 0);
    drive_b(1, 0, 2, 0);
    idle(6);
    drive_a(0, 0, 0, 0);
    drive_b(0, 0, 0, 0);
    idle(3);

    // Write then back-to-back read of addr 5.
    drive_a(1, 1, 5, 8'hC3); drain(4);
    drive_a(1, 0, 5, 0); drain(4);
    idle(3);

    // Clear while B waits; B wins in the clr_done cycle.
    drive_b(1, 0, 5, 0);
    clr_req = 1; step(); clr_req = 0;
    n = 0;
    while (bus.b_req && n < 20) begin
      step();
      n++;
      if (g_b) bus.b_req = 0;
    end
    chk("t4_gnt_cycle", n, 9);
    for (int i = 0; i < 8; i++) begin
      drive_a(1, 0, i, 0); drain(4);
    end
    idle(3);

    // Write-only traffic from B.
    for (int i = 0; i < 10; i++) begin
      drive_b(1, 1, $urandom_range(0, 7), $urandom_range(0, 255));
      step();
    end
    drive_b(0, 0, 0, 0);
    idle(3);

    // Reset with a read in flight.
    drive_a(1, 0, 2, 0); step();
    drive_a(0, 0, 0, 0);
    #2 rst = 1;
    #1 chk_reset_vals();
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold_a_rv", bus.a_rvalid, 0);
    end
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    drive_a(1, 0, 4, 0);
    drive_b(1, 0, 6, 0);
    drain(4);
    idle(4);

    // Random traffic.
    pa = 0; pb = 0;
    for (int i = 0; i < 700; i++) begin
      if (!pa) begin
        pa = ($urandom_range(0, 99) < 60);
        drive_a(pa, $urandom_range(0, 1), $urandom_range(0, 7),
                $urandom_range(0, 255));
      end
      if (!pb) begin
        pb = ($urandom_range(0, 99) < 60);
        drive_b(pb, $urandom_range(0, 1), $urandom_range(0, 7),
                $urandom_range(0, 255));
      end
      clr_req = ($urandom_range(0, 99) < 3);
      step();
      if (g_a) pa = 0;
      if (g_b) pb = 0;
    end
    clr_req = 0;
    drive_a(0, 0, 0, 0);
    drive_b(0, 0, 0, 0);
    idle(12);
    chk("rq_empty", rq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end
endmodule
